// File: rtl/clk_key_pkg.sv
// -----------------------------------------------------------------------------
// clk_key_pkg
// Shared definitions for the digital-clock key command path.
//   state_e         : setting-mode states (value equals the 'mode' output code)
//   KEY_*           : bit positions of the debounced key pulses in key_vld
//   SEL_*           : one-hot field selects driven to counters/display
//   sel_of()        : maps a state to its one-hot field select
// -----------------------------------------------------------------------------
package clk_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_HOUR = 3'b100;
  localparam logic [2:0] SEL_MIN  = 3'b010;
  localparam logic [2:0] SEL_SEC  = 3'b001;

  function automatic logic [2:0] sel_of(input state_e st);
    case (st)
      ST_SET_HOUR: return SEL_HOUR;
      ST_SET_MIN:  return SEL_MIN;
      ST_SET_SEC:  return SEL_SEC;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// -----------------------------------------------------------------------------
// cyc_timer
// Free-running cycle counter with synchronous clear, count enable and a
// terminal-count flag. Counts 0..CYC-1 while enabled, then wraps to 0.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   clr    : force counter to 0 (wins over en)
//   en     : advance counter this cycle
//   tc     : combinational flag, high in the cycle the counter wraps
// -----------------------------------------------------------------------------
module cyc_timer #(
  parameter int CYC   = 4,
  parameter int CNT_W = 29
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // tc is suppressed by clr so a clear in the wrap cycle never also fires tc.
  assign tc = en && !clr && (cnt_q == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// key_cmd_ctrl
// Turns debounced per-key press pulses into clock-setting commands: field
// selection, inc/dec pulses, save/cancel strobes and a blink enable for the
// field under edit. All outputs are registered.
//
// Optional feature: define KEY_TIMEOUT_EN to build the idle timeout, which
// drops out of a set state with cancel_pulse after TIMEOUT_CYC quiet cycles.
// Without it cancel_pulse is constant 0.
//
// Ports:
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   key_vld[2:0] : one-cycle press pulses, [0]=MODE [1]=INC [2]=DEC
//   mode[1:0]    : 0 IDLE, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   sel[2:0]     : one-hot field select (HOUR 100, MIN 010, SEC 001)
//   set_active   : high in any set state
//   inc_pulse    : one-cycle increment for the selected field
//   dec_pulse    : one-cycle decrement for the selected field
//   save_pulse   : one-cycle commit strobe on leaving SET_SEC via MODE
//   cancel_pulse : one-cycle discard strobe on timeout exit
//   blink        : display enable for the selected field, 1 = visible
// -----------------------------------------------------------------------------
module key_cmd_ctrl
  import clk_key_pkg::*;
#(
  parameter int BLINK_CYC   = 12_500_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int CNT_W       = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_vld,
  output logic [1:0] mode,
  output logic [2:0] sel,
  output logic       set_active,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       save_pulse,
  output logic       cancel_pulse,
  output logic       blink
);

  // Elaboration-time guard: both counters must fit in CNT_W bits.
  if (BLINK_CYC < 1 || TIMEOUT_CYC < 1 ||
      longint'(BLINK_CYC - 1)   >= (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CYC - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("key_cmd_ctrl: CNT_W too small for BLINK_CYC/TIMEOUT_CYC");
  end

  state_e state_q, state_d;
  logic   in_set;
  logic   inc_d, dec_d, save_d, cancel_d, blink_d;
  logic   restart;      // entering a set state or accepted inc/dec
  logic   blink_clr, blink_tc;
  logic   timeout;

  assign in_set = (state_q != ST_IDLE);
  assign mode   = state_q;

  // ---------------------------------------------------------------------------
  // Next-state and command decode. MODE beats INC/DEC; INC+DEC together is
  // dropped. Timeout only fires on a key-free cycle because any key clears
  // the timeout counter and thereby masks its terminal count.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the decision tree so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    save_d   = 1'b0;
    cancel_d = 1'b0;
    restart  = 1'b0;
    if (key_vld[KEY_MODE]) begin
      case (state_q)
        ST_IDLE:     begin state_d = ST_SET_HOUR; restart = 1'b1; end
        ST_SET_HOUR: begin state_d = ST_SET_MIN;  restart = 1'b1; end
        ST_SET_MIN:  begin state_d = ST_SET_SEC;  restart = 1'b1; end
        ST_SET_SEC:  begin state_d = ST_IDLE;     save_d  = 1'b1; end
        default:     state_d = ST_IDLE;
      endcase
    end else if (in_set) begin
      if (key_vld[KEY_INC] && !key_vld[KEY_DEC]) begin
        inc_d   = 1'b1;
        restart = 1'b1;
      end else if (key_vld[KEY_DEC] && !key_vld[KEY_INC]) begin
        dec_d   = 1'b1;
        restart = 1'b1;
      end else if (timeout) begin
        state_d  = ST_IDLE;
        cancel_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink: counter held at 0 in IDLE, restarted with blink=1 on entry or edit,
  // toggles blink every BLINK_CYC cycles otherwise.
  // ---------------------------------------------------------------------------
  assign blink_clr = (state_d == ST_IDLE) || restart;

  cyc_timer #(
    .CYC   (BLINK_CYC),
    .CNT_W (CNT_W)
  ) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (blink_clr),
    .en    (in_set),
    .tc    (blink_tc)
  );

  always_comb begin
    blink_d = blink;
    if (state_d == ST_IDLE) begin
      blink_d = 1'b0;
    end else if (restart) begin
      blink_d = 1'b1;
    end else if (blink_tc) begin
      blink_d = ~blink;
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout. Any nonzero key_vld (even an ignored combination) counts as
  // activity and restarts the wait.
  // ---------------------------------------------------------------------------
`ifdef KEY_TIMEOUT_EN
  logic to_clr;
  assign to_clr = (|key_vld) || !in_set;

  cyc_timer #(
    .CYC   (TIMEOUT_CYC),
    .CNT_W (CNT_W)
  ) u_timeout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr),
    .en    (in_set),
    .tc    (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel          <= SEL_NONE;
      set_active   <= 1'b0;
      inc_pulse    <= 1'b0;
      dec_pulse    <= 1'b0;
      save_pulse   <= 1'b0;
      cancel_pulse <= 1'b0;
      blink        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel          <= sel_of(state_d);
      set_active   <= (state_d != ST_IDLE);
      inc_pulse    <= inc_d;
      dec_pulse    <= dec_d;
      save_pulse   <= save_d;
      cancel_pulse <= cancel_d;
      blink        <= blink_d;
    end
  end

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_cmd_ctrl
// Directed self-checking bench for key_cmd_ctrl with BLINK_CYC=4 and
// TIMEOUT_CYC=20. Keys are driven #1 after a rising edge and held for one
// cycle; outputs are sampled #1 after the following rising edge.
// -----------------------------------------------------------------------------
module tb_key_cmd_ctrl;

  localparam int BLINK = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_vld = 3'b000;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       set_active, inc_pulse, dec_pulse, save_pulse, cancel_pulse, blink;

  key_cmd_ctrl #(
    .BLINK_CYC   (BLINK),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_vld      (key_vld),
    .mode         (mode),
    .sel          (sel),
    .set_active   (set_active),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .save_pulse   (save_pulse),
    .cancel_pulse (cancel_pulse),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] sel;
    logic       act;
    logic       inc;
    logic       dec;
    logic       save;
    logic       cancel;
    logic       blink;
  } out_t;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  out_t got, want;

  // Expected output word; sel and set_active follow from the mode code.
  function automatic out_t mk(input int m, input logic e_inc, input logic e_dec,
                              input logic e_save, input logic e_cancel,
                              input logic e_blink);
    out_t o;
    o.mode = 2'(m);
    case (m)
      1:       o.sel = 3'b100;
      2:       o.sel = 3'b010;
      3:       o.sel = 3'b001;
      default: o.sel = 3'b000;
    endcase
    o.act    = (m != 0);
    o.inc    = e_inc;
    o.dec    = e_dec;
    o.save   = e_save;
    o.cancel = e_cancel;
    o.blink  = e_blink;
    return o;
  endfunction

  function automatic out_t sample();
    return {mode, sel, set_active, inc_pulse, dec_pulse, save_pulse,
            cancel_pulse, blink};
  endfunction

  // Drive one cycle of key pulses, then capture outputs after the edge.
  task automatic step(input logic [2:0] k);
    key_vld = k;
    @(posedge clk);
    #1;
    key_vld = 3'b000;
    got = sample();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(3'b000);
      total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
      if (got !== want) $display("FAIL reset_init: got %b want %b", got, want);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    step(3'b001);
    step(3'b001);
    total_cnt++; want = mk(2, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL reset_enter_min: got %b want %b", got, want);
    else pass_cnt++;
    // MODE held during reset must not advance state or raise any strobe.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(3'b001);
      total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
      if (got !== want) $display("FAIL reset_mid_edit: got %b want %b", got, want);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL reset_release: got %b want %b", got, want);
    else pass_cnt++;
  endtask

  task automatic test_mode_cycle();
    int modes [4];
    modes = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      step(3'b001);
      total_cnt++; want = mk(modes[i], 0, 0, (i == 3), 0, (i != 3));
      if (got !== want) $display("FAIL mode_cycle_%0d: got %b want %b", i, got, want);
      else pass_cnt++;
    end
    step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL save_single_cycle: got %b want %b", got, want);
    else pass_cnt++;
  endtask

  task automatic test_inc_dec();
    step(3'b001);
    for (int i = 0; i < BLINK; i++) step(3'b000);
    total_cnt++; want = mk(1, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL hour_blink_off: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b010);
    total_cnt++; want = mk(1, 1, 0, 0, 0, 1);
    if (got !== want) $display("FAIL inc_accept: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b000);
    total_cnt++; want = mk(1, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL inc_single_cycle: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b100);
    total_cnt++; want = mk(1, 0, 1, 0, 0, 1);
    if (got !== want) $display("FAIL dec_accept: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b000);
    total_cnt++; want = mk(1, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL dec_single_cycle: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b001);
    step(3'b001);
    step(3'b001);
    total_cnt++; want = mk(0, 0, 0, 1, 0, 0);
    if (got !== want) $display("FAIL back_to_idle: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b010);
    total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL idle_inc_ignored: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b100);
    total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL idle_dec_ignored: got %b want %b", got, want);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    step(3'b001);
    step(3'b001);
    step(3'b011);
    total_cnt++; want = mk(3, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL mode_beats_inc: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b001);
    total_cnt++; want = mk(0, 0, 0, 1, 0, 0);
    if (got !== want) $display("FAIL sim_save: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b001);
    step(3'b001);
    step(3'b110);
    total_cnt++; want = mk(2, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL inc_dec_dropped: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b111);
    total_cnt++; want = mk(3, 0, 0, 0, 0, 1);
    if (got !== want) $display("FAIL mode_beats_both: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b001);
    total_cnt++; want = mk(0, 0, 0, 1, 0, 0);
    if (got !== want) $display("FAIL sim_exit: got %b want %b", got, want);
    else pass_cnt++;
  endtask

  task automatic test_blink();
    logic [11:0] pat;
    logic [3:0]  restart_pat;
    pat         = 12'b1111_0000_1111;  // MSB = cycle of SET_SEC entry
    restart_pat = 4'b0111;             // MSB = cycle after the inc, blink 1
    step(3'b001);
    step(3'b001);
    step(3'b001);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(3'b000);
      total_cnt++; want = mk(3, 0, 0, 0, 0, pat[11 - i]);
      if (got !== want) $display("FAIL blink_pat_%0d: got %b want %b", i, got, want);
      else pass_cnt++;
    end
    step(3'b000);
    step(3'b000);
    total_cnt++; want = mk(3, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL blink_mid_off: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b010);
    total_cnt++; want = mk(3, 1, 0, 0, 0, 1);
    if (got !== want) $display("FAIL blink_restart: got %b want %b", got, want);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step(3'b000);
      total_cnt++; want = mk(3, 0, 0, 0, 0, (i < 3));
      if (got !== want) $display("FAIL blink_after_inc_%0d: got %b want %b", i, got, want);
      else pass_cnt++;
    end
    step(3'b001);
    total_cnt++; want = mk(0, 0, 0, 1, 0, 0);
    if (got !== want) $display("FAIL blink_exit: got %b want %b", got, want);
    else pass_cnt++;
    if (restart_pat == 4'b0) $display("unused");
  endtask

  task automatic test_timeout();
`ifdef KEY_TIMEOUT_EN
    // Plain expiry: 19 quiet cycles stay, the 20th exits with cancel.
    step(3'b001);
    for (int i = 1; i < TMO; i++) begin
      step(3'b000);
      total_cnt++;
      if ({got.mode, got.save, got.cancel} !== {2'd1, 1'b0, 1'b0})
        $display("FAIL timeout_wait_%0d: got mode=%0d save=%b cancel=%b want mode=1 save=0 cancel=0",
                 i, got.mode, got.save, got.cancel);
      else pass_cnt++;
    end
    step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 1, 0);
    if (got !== want) $display("FAIL timeout_exit: got %b want %b", got, want);
    else pass_cnt++;
    step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 0, 0);
    if (got !== want) $display("FAIL cancel_single_cycle: got %b want %b", got, want);
    else pass_cnt++;
    // Key in the expiry cycle wins and restarts the wait.
    step(3'b001);
    for (int i = 1; i < TMO; i++) step(3'b000);
    step(3'b010);
    total_cnt++; want = mk(1, 1, 0, 0, 0, 1);
    if (got !== want) $display("FAIL key_blocks_timeout: got %b want %b", got, want);
    else pass_cnt++;
    for (int i = 1; i < TMO; i++) step(3'b000);
    total_cnt++;
    if ({got.mode, got.cancel} !== {2'd1, 1'b0})
      $display("FAIL timeout_restarted: got mode=%0d cancel=%b want mode=1 cancel=0",
               got.mode, got.cancel);
    else pass_cnt++;
    step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 1, 0);
    if (got !== want) $display("FAIL timeout_exit_2: got %b want %b", got, want);
    else pass_cnt++;
    // An ignored INC+DEC combination still counts as activity.
    step(3'b001);
    for (int i = 1; i < TMO; i++) step(3'b000);
    step(3'b110);
    total_cnt++;
    if ({got.mode, got.inc, got.dec, got.cancel} !== {2'd1, 3'b000})
      $display("FAIL ignored_key_blocks_timeout: got mode=%0d inc=%b dec=%b cancel=%b want mode=1 inc=0 dec=0 cancel=0",
               got.mode, got.inc, got.dec, got.cancel);
    else pass_cnt++;
    for (int i = 0; i < TMO; i++) step(3'b000);
    total_cnt++; want = mk(0, 0, 0, 0, 1, 0);
    if (got !== want) $display("FAIL timeout_exit_3: got %b want %b", got, want);
    else pass_cnt++;
`else
    step(3'b001);
    for (int i = 0; i < 2 * TMO; i++) begin
      step(3'b000);
      total_cnt++;
      if ({got.mode, got.cancel} !== {2'd1, 1'b0})
        $display("FAIL no_timeout_%0d: got mode=%0d cancel=%b want mode=1 cancel=0",
                 i, got.mode, got.cancel);
      else pass_cnt++;
    end
    step(3'b001);
    step(3'b001);
    step(3'b001);
    total_cnt++; want = mk(0, 0, 0, 1, 0, 0);
    if (got !== want) $display("FAIL no_timeout_exit: got %b want %b", got, want);
    else pass_cnt++;
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_mode_cycle();
    test_inc_dec();
    test_simultaneous();
    test_blink();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_cmd_ctrl.md
Name: key_cmd_ctrl

Overview:
- Consumer of the debounced key-event pulses from the key debouncer in the digital-clock design.
- Turns per-key one-cycle pulses into clock-setting commands:
  - mode/field selection
  - increment and decrement pulses
  - save and cancel strobes
  - a blink enable for the field being edited
- Sits between the key debouncer and the hour/min/sec counters and display driver.

Parameters:
- BLINK_CYC, 12_500_000, clk cycles per blink half-period (0.25 s at 50 MHz).
- TIMEOUT_CYC, 500_000_000, idle clk cycles in a set state before auto-exit (10 s at 50 MHz).
- CNT_W, 29, width of the internal counters; must hold TIMEOUT_CYC-1 and BLINK_CYC-1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- key_vld  input  3  debounced press pulses, one cycle per press; [0]=MODE, [1]=INC, [2]=DEC.
- mode  output  2  current state: 0=IDLE, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- sel  output  3  one-hot field select: IDLE 000, HOUR 100, MIN 010, SEC 001.
- set_active  output  1  high in any SET_* state.
- inc_pulse  output  1  one-cycle increment command for the selected field.
- dec_pulse  output  1  one-cycle decrement command for the selected field.
- save_pulse  output  1  one-cycle strobe; commit edited time.
- cancel_pulse  output  1  one-cycle strobe; discard edit (timeout exit).
- blink  output  1  display enable for the selected field; 1 = visible.

Behaviour:
- Single clock. Synchronous active-low reset: all outputs 0, state IDLE, all counters 0.
  - Reset mid-edit returns to IDLE with no save_pulse or cancel_pulse.
- All outputs are registered. A key_vld pulse sampled at edge N produces its output at edge N+1 (latency 1).
- State machine on the MODE key (key_vld[0]):
  - IDLE -> SET_HOUR -> SET_MIN -> SET_SEC.
  - SET_SEC -> IDLE, with save_pulse=1 for exactly one cycle.
- INC key (key_vld[1]) in a SET_* state: inc_pulse=1 for one cycle. Ignored in IDLE.
- DEC key (key_vld[2]) in a SET_* state: dec_pulse=1 for one cycle. Ignored in IDLE.
- Simultaneous key pulses:
  - MODE together with INC and/or DEC: MODE wins; inc/dec are dropped.
  - INC and DEC together without MODE: both dropped, no state change.
- Blink counter:
  - Runs only in SET_* states.
  - On entering a SET_* state and on every accepted inc/dec: counter cleared and blink=1.
  - When the counter reaches BLINK_CYC-1: blink toggles and the counter wraps to 0.
  - In IDLE: blink=0 and the counter is held at 0.
- Timeout counter (KEY_TIMEOUT_EN only):
  - Cleared by any nonzero key_vld, including ignored combinations.
  - Counts in SET_* states; held at 0 in IDLE.
  - On reaching TIMEOUT_CYC-1: state -> IDLE, cancel_pulse=1 for one cycle, no save_pulse.
  - A key pulse in the same cycle as expiry takes priority: counter cleared, no timeout.
- save_pulse and cancel_pulse are never high together. inc_pulse and dec_pulse are never high together.
- Counters saturate nowhere; they wrap only as stated above.

Optional Feature:
- Macro: KEY_TIMEOUT_EN.
- Defined: the timeout counter and auto-exit with cancel_pulse are present.
- Undefined: no timeout logic is built. cancel_pulse is tied to 0, and set states persist until MODE cycles back to IDLE.

Decomposition:
- Shared package clk_key_pkg:
  - state localparams ST_IDLE, ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC
  - key index constants KEY_MODE=0, KEY_INC=1, KEY_DEC=2
  - sel one-hot constants
- One natural sub-module: cyc_timer, a parameterised clear/enable counter with a terminal-count pulse. It is instanced twice, once for blink and once for timeout.

Test Plan:
All cases use BLINK_CYC=4 and TIMEOUT_CYC=20.
- Reset: drive to SET_MIN, hold rst_n=0 for 3 cycles -> mode=0, sel=000, blink=0, no save or cancel strobe.
- key_vld=001 pulsed 4 times -> mode 1,2,3,0; sel 100,010,001,000; save_pulse=1 for exactly one cycle after the 4th pulse.
- INC/DEC acceptance:
  - In SET_HOUR, key_vld=010 -> inc_pulse=1 one cycle later, single cycle; blink restarts at 1.
  - In SET_HOUR, key_vld=100 -> dec_pulse likewise.
  - In IDLE, key_vld=010 -> no inc_pulse.
- Simultaneous keys:
  - key_vld=011 in SET_MIN -> mode=3, inc_pulse=0.
  - key_vld=110 in SET_MIN -> mode stays 2, no inc or dec pulse.
- Blink: hold SET_SEC with no keys -> blink pattern 1111 0000 1111.
  - An inc at mid-pattern restarts the pattern with 4 cycles of 1.
- Timeout:
  - With KEY_TIMEOUT_EN: enter SET_HOUR, no keys for 20 cycles -> mode=0, cancel_pulse one cycle, save_pulse=0.
  - A key at cycle 19 prevents the exit.
  - Without the macro: mode stays 1 indefinitely and cancel_pulse=0.
